keypad_scan: RTL

// Scans a 4x3 telephone-style key matrix by driving one active-low column at a time and reading the rows.

---
 rtl/keypad_scan.sv | 122 ++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix scanner with frame-based debounce, one-hot digit bus, key code and press strobe.
module keypad_scan #(
  parameter int COL_HOLD   = 4,
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int HW = $clog2(COL_HOLD);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;
  localparam logic [3:0] NONE         = 4'hF;
  logic [3:0]    row_s1, row_s2;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    col_idx;
  logic [11:0]   map, map_n;
  logic [3:0]    frame_key, cand, cand_n;
  logic [1:0]    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last, frame_end, acc, rel;
  assign last      = hold_cnt == HW'(COL_HOLD - 1);
  assign frame_end = last && col_idx == 2'd2;
  // Columns float high while in reset; scanning starts on col0 the moment reset lifts.
  assign key_col   = rst ? ~(3'b001 << col_idx) : 3'b111;
  always_comb begin
    map_n = map;
    for (int r = 0; r < 4; r++) map_n[r*3 + int'(col_idx)] = ~row_s2[r];
  end
  // Map index is row*3+col; ghosts and multi-presses decode as NONE.
  always_comb begin
    frame_key = NONE;
    if (map_n != '0 && (map_n & (map_n - 12'd1)) == '0)
      for (int i = 0; i < 12; i++)
        if (map_n[i]) frame_key = i == 9 ? 4'd10 : i == 10 ? 4'd0 : i == 11 ? 4'd11 : 4'(i + 1);
  end
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    cand_n = cand;
    acc    = 1'b0;
    rel    = 1'b0;
    case (st)
      IDLE: if (frame_key != NONE) begin
        cand_n = frame_key;
        cnt_n  = CW'(1);
        acc    = DEB_FRAMES == 1;
        st_n   = acc ? HELD : PRESS_WAIT;
      end
      PRESS_WAIT: if (frame_key == cand) begin
        cnt_n = cnt + 1'b1;
        acc   = cnt_n == CW'(DEB_FRAMES);
        st_n  = acc ? HELD : PRESS_WAIT;
      end else if (frame_key != NONE) begin
        cand_n = frame_key;
        cnt_n  = CW'(1);
      end else st_n = IDLE;
      HELD: if (frame_key != cand) begin
        cnt_n = CW'(1);
        rel   = DEB_FRAMES == 1;
        st_n  = rel ? IDLE : RELEASE_WAIT;
      end
      default: if (frame_key == cand) st_n = HELD;
      else begin
        cnt_n = cnt + 1'b1;
        rel   = cnt_n == CW'(DEB_FRAMES);
        st_n  = rel ? IDLE : RELEASE_WAIT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      hold_cnt  <= '0;
      col_idx   <= '0;
      map       <= '0;
      st        <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      keypad    <= '0;
      key_star  <= 1'b0;
      key_hash  <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      row_s1    <= key_row;
      row_s2    <= row_s1;
      hold_cnt  <= last ? '0 : hold_cnt + 1'b1;
      key_valid <= frame_end && acc;
      if (last) begin
        map     <= map_n;
        col_idx <= col_idx == 2'd2 ? 2'd0 : col_idx + 1'b1;
      end
      if (frame_end) begin
        st   <= st_n;
        cnt  <= cnt_n;
        cand <= cand_n;
        if (acc) begin
          keypad   <= cand_n < 4'd10 ? 10'b1 << cand_n : '0;
          key_star <= cand_n == 4'd10;
          key_hash <= cand_n == 4'd11;
          key_code <= cand_n;
        end else if (rel) begin
          keypad   <= '0;
          key_star <= 1'b0;
          key_hash <= 1'b0;
          key_code <= '0;
        end
      end
    end
  end
endmodule
